// File: rtl/serial_addsub.sv
// serial_addsub -- digit-serial adder/subtractor.
//
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB slice
// first, and reports the result with carry/borrow and signed overflow.
// Subtraction reuses the adder: b is inverted at acceptance and the slice
// carry is preloaded with 1, giving a + ~b + 1.
//
// Parameters
//   WIDTH  operand / result width in bits (>= 2)
//   DIGIT  bits processed per cycle; WIDTH must be a multiple of DIGIT
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   operation request, only sampled while idle
//   mode    0 = a + b, 1 = a - b (sampled with start)
//   a, b    operands (sampled with start)
//   busy    high while an operation is running or completing
//   done    one-cycle pulse: result, cout and ovf are valid
//   result  sum / difference modulo 2^WIDTH, held until the next start
//   cout    add: carry out of MSB; subtract: borrow (a < b unsigned)
//   ovf     two's-complement signed overflow
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  a_r;      // shifts right one slice per RUN cycle
  logic [WIDTH-1:0]  b_r;      // already inverted for subtract
  logic              mode_r;
  logic [CW-1:0]     cnt_r;    // index of the slice being processed
  logic              carry_r;  // carry into the current slice

  logic [DIGIT+1:0]  slice_s;  // {carry out, carry into slice MSB, sum}
  logic [DIGIT-1:0]  sum_s;
  logic              cmsb_s;
  logic              cout_s;

  // Ripple add of one slice; also exposes the carry entering the slice's top
  // bit so signed overflow can be formed on the final slice.
  function automatic logic [DIGIT+1:0] slice_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             cin
  );
    logic             c;
    logic             c_msb;
    logic [DIGIT-1:0] s;
    c     = cin;
    c_msb = cin;
    s     = {DIGIT{1'b0}};
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c, c_msb, s};
  endfunction

  // Slice datapath: the lowest DIGIT bits of the shifting operand registers.
  always_comb begin
    slice_s = slice_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
  end

  assign sum_s  = slice_s[DIGIT-1:0];
  assign cmsb_s = slice_s[DIGIT];
  assign cout_s = slice_s[DIGIT+1];

  // Control FSM with all state and outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      mode_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= mode ? ~b : b;
            mode_r  <= mode;
            cnt_r   <= {CW{1'b0}};
            carry_r <= mode;   // the +1 of a + ~b + 1
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= cout_s;
          // New slice enters at the top; after N slices slice 0 sits at the LSB.
          result  <= (result >> DIGIT) | (WIDTH'(sum_s) << (WIDTH - DIGIT));
          if (cnt_r == LAST) begin
            state_r <= DONE;
            done    <= 1'b1;
            // In subtract mode a carry out means "no borrow".
            cout    <= cout_s ^ mode_r;
            ovf     <= cout_s ^ cmsb_s;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub -- directed self-checking bench for serial_addsub.
// Three instances (DIGIT = 1, 4, 8) share clock, reset and operand inputs;
// each has its own start. Expected values are hand-computed constants or the
// plain integer arithmetic in ref_op.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       mode;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] start_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [2:0] cout_v;
  logic [2:0] ovf_v;
  logic [7:0] res_v [3];

  int n_checks = 0;
  int n_errors = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
  );
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
  );
  serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nlat(input int w);
    case (w)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // Reference arithmetic: returns {ovf, cout, result}.
  function automatic logic [9:0] ref_op(input logic m, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    logic       o;
    if (!m) begin
      s = {1'b0, x} + {1'b0, y};
      o = (x[7] == y[7]) && (s[7] != x[7]);
    end else begin
      s = {1'b0, x} - {1'b0, y};
      o = (x[7] != y[7]) && (s[7] != x[7]);
    end
    return {o, s[8], s[7:0]};
  endfunction

  // Bounded wait for done on instance w; lat counts edges after acceptance.
  task automatic wait_done(input int w, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done_v[w]) break;
    end
  endtask

  task automatic do_op(input int w, input logic m, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic ec, input logic eo, input string tag);
    int lat;
    @(negedge clk);
    mode = m; a = x; b = y; start_v[w] = 1'b1;
    @(posedge clk); #1;
    start_v[w] = 1'b0;
    wait_done(w, lat);
    check_eq({tag, "_lat"}, lat, nlat(w));
    check_eq({tag, "_res"}, res_v[w], er);
    check_eq({tag, "_cout"}, cout_v[w], ec);
    check_eq({tag, "_ovf"}, ovf_v[w], eo);
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, {busy_v[w], done_v[w]}, 2'b00);
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcnt;
    logic dseen;
    logic [7:0] dres;
    logic [9:0] e;

    rst_n = 1'b0; start_v = 3'b000; mode = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", {busy_v, done_v, cout_v, ovf_v}, 12'h000);
    check_eq("rst_res", {res_v[0], res_v[1], res_v[2]}, 24'h000000);
    rst_n = 1'b1;

    // Subtract 5-3, then a start held across DONE: ignored in DONE, taken in IDLE.
    @(negedge clk);
    mode = 1'b1; a = 8'h05; b = 8'h03; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check_eq("sub_busy", busy_v[0], 1'b1);
    wait_done(0, lat);
    check_eq("sub_lat", lat, 8);
    check_eq("sub_res", res_v[0], 8'h02);
    check_eq("sub_flags", {cout_v[0], ovf_v[0]}, 2'b00);
    mode = 1'b0; a = 8'h7F; b = 8'h01; start_v[0] = 1'b1;
    @(posedge clk); #1;
    check_eq("b2b_done_ign", {busy_v[0], done_v[0]}, 2'b00);
    check_eq("b2b_hold", res_v[0], 8'h02);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check_eq("b2b_accept", busy_v[0], 1'b1);
    wait_done(0, lat);
    check_eq("b2b_lat", lat, 8);
    check_eq("b2b_res", res_v[0], 8'h80);
    check_eq("b2b_flags", {cout_v[0], ovf_v[0]}, 2'b01);
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    do_op(0, 1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "borrow");
    do_op(0, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_ovf");
    do_op(0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add_wrap");
    do_op(0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, "add_negovf");
    do_op(0, 1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "sub_posneg");
    do_op(0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "sub_zero");
    do_op(1, 1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "d4_borrow");
    do_op(1, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "d4_ovf");
    do_op(2, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "d8_wrap");
    do_op(2, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "d8_ovf");

    // Busy rejection: a second start with new operands mid-run is ignored.
    @(negedge clk);
    mode = 1'b0; a = 8'h20; b = 8'h07; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    bcnt = 0; dseen = 1'b0; dres = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (!busy_v[0]) break;
      bcnt++;
      if (done_v[0]) begin
        dseen = 1'b1;
        dres  = res_v[0];
      end
      if (i == 2) begin
        start_v[0] = 1'b1; a = 8'h10; b = 8'h01; mode = 1'b1;
      end else begin
        start_v[0] = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0;
    check_eq("busy_len", bcnt, 9);
    check_eq("busy_done", dseen, 1'b1);
    check_eq("busy_res", dres, 8'h27);
    @(posedge clk); #1;
    check_eq("busy_norestart", busy_v[0], 1'b0);
    check_eq("busy_hold", {res_v[0], cout_v[0], ovf_v[0]}, {8'h27, 2'b00});

    // Reset in the middle of RUN, with start asserted on the reset edge.
    @(negedge clk);
    mode = 1'b0; a = 8'h55; b = 8'h0F; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start_v[0] = 1'b0;
    check_eq("midrst_state", {busy_v[0], done_v[0], cout_v[0], ovf_v[0]}, 4'h0);
    check_eq("midrst_res", res_v[0], 8'h00);
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) dcnt++;
      if (busy_v[0]) bcnt++;
    end
    check_eq("midrst_nodone", dcnt, 0);
    check_eq("midrst_nobusy", bcnt, 0);
    do_op(0, 1'b0, 8'h55, 8'h0F, 8'h64, 1'b0, 1'b0, "after_rst");

    // Strided sweep against reference arithmetic on all three instances.
    for (int w = 0; w < 3; w++) begin
      for (int m = 0; m < 2; m++) begin
        for (int x = 0; x < 256; x += (w == 0) ? 51 : 15) begin
          for (int y = 0; y < 256; y += (w == 0) ? 37 : 17) begin
            e = ref_op(m[0], x[7:0], y[7:0]);
            do_op(w, m[0], x[7:0], y[7:0], e[7:0], e[8], e[9], "sweep");
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL take parameter DIGIT, default 1, as the bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high in the RUN and DONE states.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: sum or difference modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: in add mode, carry out of the MSB; in subtract mode, borrow (1 iff a < b unsigned).
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the operation.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL latch a, b and mode, clear the digit counter, load the internal carry with mode, and enter RUN.
REQ-015 Subtraction SHALL be computed as a + ~b + 1, using the carry preload from REQ-014; there SHALL be no separate subtractor datapath.
REQ-016 In RUN, each edge SHALL process one DIGIT-bit slice, LSB slice first: it adds the a slice, the (possibly inverted) b slice and the carry, writes the slice sum into result, and registers the slice carry-out.
REQ-017 After the edge that processes slice N-1, the block SHALL enter DONE. At that point done=1, cout and ovf are valid, and result holds the complete value.
REQ-018 Latency: done SHALL go high exactly N cycles after the edge that accepted start. It SHALL stay high for exactly one cycle, after which the FSM returns to IDLE.
REQ-019 cout SHALL equal the final carry in add mode and its inverse in subtract mode.
REQ-020 ovf SHALL be (carry into MSB) XOR (carry out of MSB).
REQ-021 Operand handling: start while busy=1 SHALL be ignored, and changes on a, b and mode after acceptance SHALL NOT affect the running operation.
REQ-022 Output hold: result, cout and ovf SHALL hold their values from DONE until the next accepted start. From that start until the next done, result SHALL be treated as undefined by the consumer.
REQ-023 Back-to-back: start sampled in IDLE on the cycle immediately after DONE SHALL be accepted, giving a minimum issue interval of N+2 cycles.
REQ-024 The counter SHALL be sized ceil(log2(N+1)) bits. With DIGIT = WIDTH (N = 1), done SHALL follow start by one cycle.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force the FSM to IDLE and set busy=0, done=0, result=0, cout=0, ovf=0, clearing the counter and internal carry.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse. start sampled in the same edge as rst_n=0 SHALL be ignored.
REQ-027 Reset SHALL have no asynchronous path; outputs SHALL change only on a clk edge.

Verification (WIDTH=8, DIGIT=1 unless noted)
REQ-028 Subtract: mode=1, a=0x05, b=0x03 -> 8 cycles after start: done=1, result=0x02, cout=0, ovf=0.
REQ-029 Borrow: mode=1, a=0x03, b=0x05 -> result=0xFE, cout=1, ovf=0. Signed overflow: mode=1, a=0x80, b=0x01 -> result=0x7F, ovf=1.
REQ-030 Add wrap: mode=0, a=0xFF, b=0x01 -> result=0x00, cout=1, ovf=0. Signed overflow: mode=0, a=0x7F, b=0x01 -> result=0x80, cout=0, ovf=1.
REQ-031 Busy rejection: second start with a=0x10 during RUN -> ignored; the first result is unaffected; busy stays high for exactly 9 cycles.
REQ-032 Reset mid-operation: rst_n=0 at cycle 4 of RUN -> next cycle busy=0, result=0, and done never pulses; a fresh start then completes normally.
REQ-033 Parameter sweep: DIGIT=4 gives done 2 cycles after start; DIGIT=8 gives 1 cycle. Exhaustive 8-bit a, b in both modes matches the reference arithmetic for result, cout and ovf.
